// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect arbiters.
//   state_t        : arbiter FSM encoding (idle / address phase / data phase)
//   onehot_to_idx  : converts a one-hot vector of up to 16 bits to its index
package axi_ic_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } state_t;

    // Input must be one-hot or zero; zero maps to index 0.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_arbiter_r_rr_if.sv
// Read-channel arbitration bundle between the masters' AR request lines,
// the muxed R channel and the arbiter.
//   m_ARVALID  : per-master AR request
//   ARREADY    : AR ready from the selected slave path
//   RVALID     : muxed read-data valid
//   RREADY     : read-data ready of the granted master
//   RLAST      : muxed last-beat flag
//   m_rgrnt    : one-hot grant
//   rgrnt_idx  : binary index of the granted master
//   busy       : arbiter in address or data phase
//   timeout_err: one-cycle watchdog pulse
// Modports: slave = arbiter side, master = request/data-path side.
interface axi_arbiter_r_rr_if #(
    parameter int NUM_M = 4
) ();
    localparam int IDX_W = $clog2(NUM_M);

    logic [NUM_M-1:0] m_ARVALID;
    logic             ARREADY;
    logic             RVALID;
    logic             RREADY;
    logic             RLAST;
    logic [NUM_M-1:0] m_rgrnt;
    logic [IDX_W-1:0] rgrnt_idx;
    logic             busy;
    logic             timeout_err;

    modport slave (
        input  m_ARVALID, ARREADY, RVALID, RREADY, RLAST,
        output m_rgrnt, rgrnt_idx, busy, timeout_err
    );

    modport master (
        output m_ARVALID, ARREADY, RVALID, RREADY, RLAST,
        input  m_rgrnt, rgrnt_idx, busy, timeout_err
    );
endinterface

// File: rtl/axi_arbiter_r_rr_rr_pick.sv
// Combinational priority picker.
//   req     : request vector
//   ptr     : index of the last served requester (round-robin only)
//   rr_mode : 1 = search from ptr+1 with wrap, 0 = lowest index wins
//   win     : one-hot winner (zero when no request)
//   vld     : at least one request present
module rr_pick #(
    parameter int NUM_M = 4,
    parameter int IDX_W = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_mode,
    output logic [NUM_M-1:0] win,
    output logic             vld
);
    int   pos;
    logic found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NUM_M; k++) begin
            pos = rr_mode ? (int'(ptr) + 1 + k) % NUM_M : k;
            if (req[pos] && !found) begin
                win[pos] = 1'b1;
                found    = 1'b1;
            end
        end
        vld = |req;
    end
endmodule

// File: rtl/axi_arbiter_r_rr.sv
// AXI4 read-channel arbiter. Grants one of NUM_M masters the shared AR/R
// path from arbitration until the last read beat, with round-robin or
// fixed-priority selection and a data-phase watchdog.
//   ACLK    : clock
//   ARESETn : asynchronous active-low reset
//   bus     : request/grant bundle (see axi_arbiter_r_rr_if)
// Parameters: NUM_M (2..16), RR_MODE (1 = round-robin, 0 = fixed priority),
// TIMEOUT (watchdog limit, 0 disables), TCO (output delay for simulation
// models; the synthesizable registers add none).
module axi_arbiter_r_rr
    import axi_ic_pkg::*;
#(
    parameter int NUM_M   = 4,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 256,
    parameter int TCO     = 1
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    axi_arbiter_r_rr_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_M);
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic             WD_EN   = (TIMEOUT > 0);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_M - 1);

    if (NUM_M < 2 || NUM_M > 16 || TCO < 0) begin : g_bad_param
        $error("axi_arbiter_r_rr: NUM_M must be 2..16 and TCO non-negative");
    end

    state_t           state;
    logic [NUM_M-1:0] grnt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] ptr;
    logic             busy_q;
    logic             terr;
    logic [WD_W-1:0]  wdog;

    logic [NUM_M-1:0] pick_win;
    logic             pick_vld;
    logic             ar_held;
    logic             r_hs;

    rr_pick #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (bus.m_ARVALID),
        .ptr     (ptr),
        .rr_mode (RR_MODE != 0),
        .win     (pick_win),
        .vld     (pick_vld)
    );

    // Only the granted master's ARVALID matters once a grant is issued.
    assign ar_held = |(bus.m_ARVALID & grnt);
    assign r_hs    = bus.RVALID & bus.RREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state  <= ARB_IDLE;
            grnt   <= '0;
            idx    <= '0;
            ptr    <= PTR_RST;
            busy_q <= 1'b0;
            terr   <= 1'b0;
            wdog   <= '0;
        end else begin
            terr <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        state  <= ARB_ADDR;
                        grnt   <= pick_win;
                        idx    <= IDX_W'(onehot_to_idx(16'(pick_win)));
                        busy_q <= 1'b1;
                    end
                end
                ARB_ADDR: begin
                    if (!ar_held) begin
                        // Request withdrawn before the handshake: abandon
                        // the grant without advancing the rotation.
                        state  <= ARB_IDLE;
                        grnt   <= '0;
                        idx    <= '0;
                        busy_q <= 1'b0;
                    end else if (bus.ARREADY) begin
                        state <= ARB_DATA;
                        wdog  <= '0;
                    end
                end
                ARB_DATA: begin
                    if (r_hs) begin
                        wdog <= '0;
                        if (bus.RLAST) begin
                            state  <= ARB_IDLE;
                            grnt   <= '0;
                            idx    <= '0;
                            busy_q <= 1'b0;
                            ptr    <= idx;
                        end
                    end else if (WD_EN && wdog == WD_LAST) begin
                        // Hung burst: release and treat the holder as served.
                        terr   <= 1'b1;
                        state  <= ARB_IDLE;
                        grnt   <= '0;
                        idx    <= '0;
                        busy_q <= 1'b0;
                        ptr    <= idx;
                    end else if (WD_EN && wdog != WD_MAX) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    state  <= ARB_IDLE;
                    grnt   <= '0;
                    idx    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.m_rgrnt     = grnt;
    assign bus.rgrnt_idx   = idx;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr;
endmodule

// File: tb/tb_axi_arbiter_r_rr.sv
// Bench for axi_arbiter_r_rr: three instances (round-robin/TIMEOUT=16,
// fixed-priority/watchdog off, round-robin/TIMEOUT=8) share one stimulus
// stream and are checked every cycle against a per-instance reference
// model, plus directed literal expectations.
module tb_axi_arbiter_r_rr;
    localparam int N  = 4;
    localparam int NI = 3;

    typedef struct packed {
        logic has;
        int   g;
        logic data;
        int   ptr;
        int   stall;
        logic err;
    } mstate_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] ar;
    logic         arready, rvalid, rready, rlast;
    logic         chk_on;

    int vectors;
    int miscompares;

    axi_arbiter_r_rr_if #(.NUM_M(N)) if_a ();
    axi_arbiter_r_rr_if #(.NUM_M(N)) if_b ();
    axi_arbiter_r_rr_if #(.NUM_M(N)) if_c ();

    assign if_a.m_ARVALID = ar;
    assign if_a.ARREADY   = arready;
    assign if_a.RVALID    = rvalid;
    assign if_a.RREADY    = rready;
    assign if_a.RLAST     = rlast;
    assign if_b.m_ARVALID = ar;
    assign if_b.ARREADY   = arready;
    assign if_b.RVALID    = rvalid;
    assign if_b.RREADY    = rready;
    assign if_b.RLAST     = rlast;
    assign if_c.m_ARVALID = ar;
    assign if_c.ARREADY   = arready;
    assign if_c.RVALID    = rvalid;
    assign if_c.RREADY    = rready;
    assign if_c.RLAST     = rlast;

    axi_arbiter_r_rr #(.NUM_M(N), .RR_MODE(1), .TIMEOUT(16), .TCO(1)) u_a (
        .ACLK(clk), .ARESETn(rst_n), .bus(if_a.slave));
    axi_arbiter_r_rr #(.NUM_M(N), .RR_MODE(0), .TIMEOUT(0), .TCO(1)) u_b (
        .ACLK(clk), .ARESETn(rst_n), .bus(if_b.slave));
    axi_arbiter_r_rr #(.NUM_M(N), .RR_MODE(1), .TIMEOUT(8), .TCO(1)) u_c (
        .ACLK(clk), .ARESETn(rst_n), .bus(if_c.slave));

    logic [N-1:0] d_grnt [NI];
    logic [1:0]   d_idx  [NI];
    logic         d_busy [NI];
    logic         d_err  [NI];

    assign d_grnt[0] = if_a.m_rgrnt;  assign d_idx[0] = if_a.rgrnt_idx;
    assign d_busy[0] = if_a.busy;     assign d_err[0] = if_a.timeout_err;
    assign d_grnt[1] = if_b.m_rgrnt;  assign d_idx[1] = if_b.rgrnt_idx;
    assign d_busy[1] = if_b.busy;     assign d_err[1] = if_b.timeout_err;
    assign d_grnt[2] = if_c.m_rgrnt;  assign d_idx[2] = if_c.rgrnt_idx;
    assign d_busy[2] = if_c.busy;     assign d_err[2] = if_c.timeout_err;

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    function automatic int inst_rr(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    function automatic int inst_to(input int i);
        case (i)
            0:       return 16;
            1:       return 0;
            default: return 8;
        endcase
    endfunction

    function automatic mstate_t model_reset();
        mstate_t s;
        s.has = 1'b0; s.g = 0; s.data = 1'b0;
        s.ptr = N - 1; s.stall = 0; s.err = 1'b0;
        return s;
    endfunction

    // One clock of the arbitration rules for one instance.
    function automatic mstate_t model_next(input mstate_t s, input int rr, input int to,
                                           input logic [N-1:0] req, input logic ardy,
                                           input logic rv, input logic rd, input logic rl);
        mstate_t n;
        int w;
        n = s;
        n.err = 1'b0;
        if (!s.has) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (rr != 0) ? (s.ptr + k) % N : k - 1;
                if (w < 0 && req[j]) w = j;
            end
            if (w >= 0) begin
                n.has = 1'b1; n.g = w; n.data = 1'b0;
            end
        end else if (!s.data) begin
            if (!req[s.g]) n.has = 1'b0;
            else if (ardy) begin n.data = 1'b1; n.stall = 0; end
        end else if (rv && rd) begin
            n.stall = 0;
            if (rl) begin n.ptr = s.g; n.has = 1'b0; n.data = 1'b0; end
        end else if (to > 0 && s.stall == to - 1) begin
            n.err = 1'b1; n.ptr = s.g; n.has = 1'b0; n.data = 1'b0;
        end else if (to > 0 && s.stall < to) begin
            n.stall = s.stall + 1;
        end
        return n;
    endfunction

    mstate_t ms [NI];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) ms[i] <= model_reset();
        end else begin
            for (int i = 0; i < NI; i++)
                ms[i] <= model_next(ms[i], inst_rr(i), inst_to(i), ar, arready, rvalid, rready, rlast);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every instance against its model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("model_i%0d_grnt", i), int'(d_grnt[i]), ms[i].has ? (1 << ms[i].g) : 0);
                chk($sformatf("model_i%0d_idx", i), int'(d_idx[i]), ms[i].has ? ms[i].g : 0);
                chk($sformatf("model_i%0d_busy", i), int'(d_busy[i]), int'(ms[i].has));
                chk($sformatf("model_i%0d_err", i), int'(d_err[i]), int'(ms[i].err));
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; ar = '0; arready = 1'b0;
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Assumes the granted master is in the address phase and keeps ARVALID.
    task automatic serve(input int beats);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int b = 0; b < beats; b++) begin
            rvalid = 1'b1; rready = 1'b1; rlast = (b == beats - 1);
            @(negedge clk);
        end
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    endtask

    initial begin
        int first;
        int pulses;
        vectors = 0; miscompares = 0; chk_on = 1'b0;
        rst_n = 1'b0; ar = '0; arready = 1'b0;
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_grnt", int'(d_grnt[i]), 0);
            chk("rst_idx", int'(d_idx[i]), 0);
            chk("rst_busy", int'(d_busy[i]), 0);
            chk("rst_err", int'(d_err[i]), 0);
        end
        rst_n = 1'b1;

        // Two requesters, 4-beat burst, then rotation to master 2.
        ar = 4'b0101;
        @(negedge clk);
        chk("t1_first_grnt", int'(d_grnt[0]), 1);
        chk("t1_first_idx", int'(d_idx[0]), 0);
        chk("t1_first_busy", int'(d_busy[0]), 1);
        serve(4);
        chk("t1_drop_grnt", int'(d_grnt[0]), 0);
        chk("t1_drop_busy", int'(d_busy[0]), 0);
        @(negedge clk);
        chk("t1_rr_next_grnt", int'(d_grnt[0]), 4);
        chk("t1_rr_next_idx", int'(d_idx[0]), 2);
        chk("t1_fix_next_grnt", int'(d_grnt[1]), 1);

        // Fairness with all four requesting.
        do_reset();
        ar = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t2_rr_seq%0d", k), int'(d_idx[0]), k % 4);
            chk($sformatf("t2_fix_seq%0d", k), int'(d_idx[1]), 0);
            serve(1);
        end

        // Mid-burst stall does not release the grant.
        do_reset();
        ar = 4'b0010;
        @(negedge clk);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_stall_grnt", int'(d_grnt[0]), 2);
            chk("t3_stall_busy", int'(d_busy[0]), 1);
        end
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        @(negedge clk);
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        chk("t3_end_grnt", int'(d_grnt[0]), 0);

        // Watchdog on the TIMEOUT=8 instance.
        do_reset();
        ar = 4'b0001;
        @(negedge clk);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        ar = 4'b0011;
        first = -1; pulses = 0;
        for (int s = 1; s <= 12; s++) begin
            @(negedge clk);
            if (d_err[2]) begin
                pulses++;
                if (first < 0) first = s;
            end
            if (s == 8) chk("t4_wd_drop_grnt", int'(d_grnt[2]), 0);
            if (s == 9) chk("t4_wd_next_grnt", int'(d_grnt[2]), 2);
        end
        chk("t4_wd_step", first, 8);
        chk("t4_wd_pulses", pulses, 1);
        chk("t4_a_still_held", int'(d_grnt[0]), 1);

        // Grant holder withdraws in the address phase.
        do_reset();
        ar = 4'b0001;
        @(negedge clk);
        serve(1);
        ar = 4'b0110;
        @(negedge clk);
        chk("t5_grant_m1", int'(d_grnt[0]), 2);
        ar = 4'b0100;
        @(negedge clk);
        chk("t5_withdraw_grnt", int'(d_grnt[0]), 0);
        chk("t5_withdraw_busy", int'(d_busy[0]), 0);
        ar = 4'b0110;
        @(negedge clk);
        chk("t5_regrant_grnt", int'(d_grnt[0]), 2);
        chk("t5_regrant_idx", int'(d_idx[0]), 1);

        // Asynchronous reset in the data phase.
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("t6_in_data_busy", int'(d_busy[0]), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_grnt", int'(d_grnt[0]), 0);
        chk("t6_async_busy", int'(d_busy[0]), 0);
        chk("t6_async_idx", int'(d_idx[0]), 0);
        @(negedge clk);
        ar = 4'b1111;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_after_rst_grnt", int'(d_grnt[0]), 1);

        // Randomized traffic with periodic stalls and rare resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            ar      = 4'($urandom_range(0, 15));
            arready = ($urandom_range(0, 9) < 4);
            rvalid  = ($urandom_range(0, 9) < 7);
            rready  = ($urandom_range(0, 9) < 7);
            rlast   = ($urandom_range(0, 3) == 0);
            if ((n % 200) < 24) rvalid = 1'b0;
            rst_n   = ($urandom_range(0, 499) != 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axi_arbiter_r_rr.md
Name: axi_arbiter_r_rr

Overview:
- Parametrised read-channel arbiter for the AXI4 interconnect.
- Grants one of NUM_M masters access to the shared AR/R path. The grant is held from arbitration until the last read beat completes.
- Supports round-robin or fixed-priority selection, selected by parameter.
- Adds a data-phase watchdog that releases a hung grant and flags an error. Sits between the master-side AR request lines and the AR/R multiplexers, which it drives with a one-hot grant and an index.

Parameters:
- NUM_M, 4: number of masters, 2..16.
- RR_MODE, 1: 1 = round-robin; 0 = fixed priority, master 0 highest.
- TIMEOUT, 256: watchdog limit in cycles without an R handshake during the data phase; 0 disables the watchdog.
- TCO, 1: register output delay for simulation.

Ports:
- ACLK  input  1  clock.
- ARESETn  input  1  asynchronous active-low reset.
- m_ARVALID  input  NUM_M  per-master AR request.
- ARREADY  input  1  AR ready from the selected slave path.
- RVALID  input  1  muxed read-data valid.
- RREADY  input  1  read-data ready of the granted master.
- RLAST  input  1  muxed last-beat flag.
- m_rgrnt  output  NUM_M  one-hot grant, registered.
- rgrnt_idx  output  $clog2(NUM_M)  binary index of the granted master; 0 when no grant.
- busy  output  1  high in ADDR or DATA.
- timeout_err  output  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Clock and reset: one clock, ACLK. Reset ARESETn is asynchronous, active-low, and applies to all state registers.
- Reset values:
  - state = IDLE; m_rgrnt = 0; rgrnt_idx = 0; busy = 0; timeout_err = 0.
  - Priority pointer = NUM_M-1, so master 0 wins first.
  - Watchdog counter = 0.
- State IDLE:
  - If any m_ARVALID is high, the winner is selected combinationally and registered. The next cycle is ADDR with the winner's grant bit set.
  - If no request is present, stay in IDLE with no grant.
- Selection rule:
  - RR_MODE=1: search starts at pointer+1, wrapping modulo NUM_M; the first set request wins.
  - RR_MODE=0: the lowest index with a set request wins. The pointer is ignored.
- State ADDR:
  - If m_ARVALID[g] & ARREADY (AR handshake): go to DATA and clear the watchdog.
  - If m_ARVALID[g] drops before the handshake (protocol violation): go to IDLE and drop the grant. The pointer is unchanged.
  - Otherwise hold.
  - ARVALID of non-granted masters is ignored.
- State DATA:
  - Grant holds.
  - Each RVALID & RREADY clears the watchdog; otherwise the watchdog increments, saturating at TIMEOUT.
  - RVALID & RREADY & RLAST: go to IDLE, drop the grant, and set pointer = g.
  - RVALID or RREADY deasserting mid-burst does NOT release the grant.
- Watchdog:
  - Active only when TIMEOUT>0 and state = DATA.
  - When the counter reaches TIMEOUT-1 with no handshake in that cycle: pulse timeout_err for one cycle, go to IDLE, drop the grant, set pointer = g.
  - A handshake in the same cycle takes precedence; no error.
  - Counter width: $clog2(TIMEOUT+1).
- Latency:
  - Request in IDLE to grant visible: 1 cycle.
  - Last beat handshake to grant dropped: 1 cycle.
  - Minimum gap between consecutive grants: 1 IDLE cycle.
- Simultaneous events:
  - New requests arriving during ADDR/DATA are only considered in IDLE.
  - A master whose request stays high wins again only after all higher-rotation requesters are served (RR mode).
- Reset mid-burst: the grant drops immediately (asynchronously) and the pointer returns to NUM_M-1.
- Outputs are all registered; m_rgrnt and rgrnt_idx are always mutually consistent and at most one grant bit is set.

Decomposition:
- Shared package axi_ic_pkg:
  - state typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA}.
  - Function onehot_to_idx.
- One sub-module, rr_pick:
  - Combinational parametrised priority picker.
  - Inputs: req[NUM_M], ptr, rr_mode.
  - Outputs: one-hot winner and valid.
  - Reused by the write-channel arbiter successor.

Test Plan:
- Reset, then m_ARVALID=4'b0101: next cycle m_rgrnt=0001, idx=0. After AR handshake and a 4-beat burst ending in RLAST, the next grant is 0100, idx=2.
- RR fairness, all 4 requesting continuously with 1-beat bursts: grant sequence 0,1,2,3,0. Fixed mode (RR_MODE=0), same stimulus: grant sequence 0,0,0.
- Mid-burst stall: RVALID=0 and RREADY=0 for 10 cycles in DATA. Grant is held and busy=1; no transition to IDLE.
- Watchdog with TIMEOUT=8: after the AR handshake, no R beats. timeout_err pulses exactly once 8 cycles later and the grant drops. The next requester is the pointer's successor.
- Grant-holder withdraws: m_ARVALID[1] drops while in ADDR. Return to IDLE with grant 0 and the pointer unchanged; master 1 re-requesting wins again before master 2.
- ARESETn asserted during DATA: m_rgrnt=0 and busy=0 immediately. After release, master 0 has top priority.
